// File: rtl/ram_hs.sv
// ram_hs: single-port synchronous RAM with a valid/ready request port, a
// post-reset clear sequencer and a fixed-latency in-order response pipeline.
module ram_hs #(
   parameter  int WORD_SIZE    = 20,
   parameter  int WORD_AMOUNT  = 30,
   parameter  int READ_LATENCY = 2,
   localparam int ADDR_W       = (WORD_AMOUNT > 1) ? $clog2(WORD_AMOUNT) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_op,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [WORD_SIZE-1:0] resp_rdata,
   output logic                 resp_err
);
   localparam int unsigned       LAT   = READ_LATENCY;
   localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(WORD_AMOUNT);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(WORD_AMOUNT - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t               state;
   logic [ADDR_W-1:0]    clr_cnt;
   logic [WORD_SIZE-1:0] mem [WORD_AMOUNT];

   logic                 pv [LAT];
   logic                 pe [LAT];
   logic [WORD_SIZE-1:0] pd [LAT];

   logic                 accept;
   logic                 in_range;
   logic                 mem_we;
   logic [ADDR_W-1:0]    mem_waddr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [WORD_SIZE-1:0] rd_word;

   // One write port shared by the clear sequencer and accepted writes;
   // req_ready is only high in RUN, so the two never compete.
   always_comb begin
      accept    = req_valid & req_ready & ~rst;
      in_range  = ({1'b0, req_addr} < LIMIT);
      rd_word   = '0;
      if (accept && in_range && !req_op)
         rd_word = mem[req_addr];
      mem_we    = 1'b0;
      mem_waddr = req_addr;
      mem_wdata = req_wdata;
      if (state == CLEAR) begin
         mem_we    = ~rst;
         mem_waddr = clr_cnt;
         mem_wdata = '0;
      end else if (accept && in_range && req_op) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= CLEAR;
         clr_cnt   <= '0;
         req_ready <= 1'b0;
         for (int unsigned i = 0; i < LAT; i++) begin
            pv[i] <= 1'b0;
            pe[i] <= 1'b0;
            pd[i] <= '0;
         end
      end else begin
         case (state)
            CLEAR: begin
               if (clr_cnt == LAST) begin
                  state     <= RUN;
                  req_ready <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            RUN: ;
            default: state <= CLEAR;
         endcase
         // Stage 0 is loaded at the accept edge, so LAT stages give LAT-1 edges of delay.
         pv[0] <= accept;
         pe[0] <= accept & ~in_range;
         pd[0] <= rd_word;
         for (int unsigned i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end

   assign resp_valid = pv[LAT-1];
   assign resp_err   = pe[LAT-1];
   assign resp_rdata = pd[LAT-1];

endmodule

// File: tb/tb_ram_hs.sv
// Self-checking bench for ram_hs: a default instance plus READ_LATENCY=1/4
// instances (16 x 8) compared against an array/queue reference model.
module tb_ram_hs;
   typedef struct packed {
      logic [31:0] stamp;
      logic        err;
      logic [19:0] data;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   int checks   = 0;
   int failures = 0;

   logic        rst;
   logic        rv, rop, rready, resp_v, rerr;
   logic [4:0]  raddr;
   logic [19:0] rwd, rdata;

   logic        sv, sop;
   logic [3:0]  saddr;
   logic [7:0]  swd;
   logic        s1_ready, s1_v, s1_e, s4_ready, s4_v, s4_e;
   logic [7:0]  s1_d, s4_d;

   logic [19:0] mdl [30];
   logic [7:0]  ms  [16];
   rsp_t exp_q[$], obs_q[$], exp1_q[$], obs1_q[$], exp4_q[$], obs4_q[$];

   ram_hs dut (
      .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rready), .req_op(rop),
      .req_addr(raddr), .req_wdata(rwd), .resp_valid(resp_v), .resp_rdata(rdata),
      .resp_err(rerr)
   );

   ram_hs #(.WORD_SIZE(8), .WORD_AMOUNT(16), .READ_LATENCY(1)) dut_l1 (
      .clk(clk), .rst(rst), .req_valid(sv), .req_ready(s1_ready), .req_op(sop),
      .req_addr(saddr), .req_wdata(swd), .resp_valid(s1_v), .resp_rdata(s1_d),
      .resp_err(s1_e)
   );

   ram_hs #(.WORD_SIZE(8), .WORD_AMOUNT(16), .READ_LATENCY(4)) dut_l4 (
      .clk(clk), .rst(rst), .req_valid(sv), .req_ready(s4_ready), .req_op(sop),
      .req_addr(saddr), .req_wdata(swd), .resp_valid(s4_v), .resp_rdata(s4_d),
      .resp_err(s4_e)
   );

   // Response recorder: stamps each response with the edge it followed.
   always @(negedge clk) begin
      if (resp_v) obs_q.push_back({32'(ecnt), rerr, rdata});
      if (s1_v)   obs1_q.push_back({32'(ecnt), s1_e, 12'h000, s1_d});
      if (s4_v)   obs4_q.push_back({32'(ecnt), s4_e, 12'h000, s4_d});
   end

   // Called at a falling edge; the request is accepted at the next rising edge.
   task automatic issue(input bit op, input int addr, input logic [19:0] wd);
      rsp_t e;
      rv = 1'b1; rop = op; raddr = addr[4:0]; rwd = wd;
      e.stamp = 32'(ecnt + 2);
      e.err   = (addr >= 30);
      e.data  = (!op && addr < 30) ? mdl[addr] : 20'h0;
      if (op && addr < 30) mdl[addr] = wd;
      exp_q.push_back(e);
      @(negedge clk);
      rv = 1'b0;
   endtask

   task automatic issue_s(input bit op, input int addr, input logic [7:0] wd);
      logic [7:0] rd;
      sv = 1'b1; sop = op; saddr = addr[3:0]; swd = wd;
      rd = op ? 8'h00 : ms[addr];
      exp1_q.push_back({32'(ecnt + 1), 1'b0, 12'h000, rd});
      exp4_q.push_back({32'(ecnt + 4), 1'b0, 12'h000, rd});
      if (op) ms[addr] = wd;
      @(negedge clk);
      sv = 1'b0;
   endtask

   task automatic do_reset();
      int n;
      rst = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].stamp >= 32'(ecnt + 1)) void'(exp_q.pop_back());
      while (exp1_q.size() > 0 && exp1_q[$].stamp >= 32'(ecnt + 1)) void'(exp1_q.pop_back());
      while (exp4_q.size() > 0 && exp4_q[$].stamp >= 32'(ecnt + 1)) void'(exp4_q.pop_back());
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rready, resp_v, rerr, rdata} !== 23'h0) begin
         failures++;
         $display("FAIL reset_values: got ready=%0b valid=%0b err=%0b rdata=%h expected all 0",
                  rready, resp_v, rerr, rdata);
      end
      for (int w = 0; w < 30; w++) mdl[w] = '0;
      for (int w = 0; w < 16; w++) ms[w] = '0;
      // Hold a write during the clear; it must be ignored.
      rst = 1'b0; rv = 1'b1; rop = 1'b1; raddr = 5'd3; rwd = 20'hFFFFF;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rready && n < 100);
      rv = 1'b0;
      checks++;
      if (n != 30) begin
         failures++;
         $display("FAIL clear_cycles: ready after %0d cycles expected 30", n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int a = 0; a < 30; a++) issue(1'b0, a, 20'h0);
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL reset_read count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL reset_read[%0d]: got cyc=%0d err=%0b data=%h expected cyc=%0d err=%0b data=%h",
                     i, obs_q[i].stamp, obs_q[i].err, obs_q[i].data, exp_q[i].stamp, exp_q[i].err, exp_q[i].data);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_write_read();
      issue(1'b1, 5, 20'hABCDE);
      issue(1'b0, 5, 20'h0);
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL write_read count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL write_read[%0d]: got cyc=%0d err=%0b data=%h expected cyc=%0d err=%0b data=%h",
                     i, obs_q[i].stamp, obs_q[i].err, obs_q[i].data, exp_q[i].stamp, exp_q[i].err, exp_q[i].data);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 30; a++) issue(1'b1, a, 20'(a * 3));
      for (int a = 0; a < 30; a++) issue(1'b0, a, 20'h0);
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL back_to_back count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL back_to_back[%0d]: got cyc=%0d err=%0b data=%h expected cyc=%0d err=%0b data=%h",
                     i, obs_q[i].stamp, obs_q[i].err, obs_q[i].data, exp_q[i].stamp, exp_q[i].err, exp_q[i].data);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 20'($urandom));
      end
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL random count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL random[%0d]: got cyc=%0d err=%0b data=%h expected cyc=%0d err=%0b data=%h",
                     i, obs_q[i].stamp, obs_q[i].err, obs_q[i].data, exp_q[i].stamp, exp_q[i].err, exp_q[i].data);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_out_of_range();
      issue(1'b0, 31, 20'hFFFFF);
      issue(1'b1, 31, 20'hFFFFF);
      issue(1'b1, 30, 20'hFFFFF);
      for (int a = 0; a < 30; a++) issue(1'b0, a, 20'h0);
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL out_of_range count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL out_of_range[%0d]: got cyc=%0d err=%0b data=%h expected cyc=%0d err=%0b data=%h",
                     i, obs_q[i].stamp, obs_q[i].err, obs_q[i].data, exp_q[i].stamp, exp_q[i].err, exp_q[i].data);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_midstream();
      issue(1'b1, 5, 20'h5A5A5);
      for (int k = 0; k < 4; k++) issue(1'b0, 5 + k, 20'h0);
      do_reset();
      issue(1'b0, 5, 20'h0);
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL reset_midstream count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL reset_midstream[%0d]: got cyc=%0d err=%0b data=%h expected cyc=%0d err=%0b data=%h",
                     i, obs_q[i].stamp, obs_q[i].err, obs_q[i].data, exp_q[i].stamp, exp_q[i].err, exp_q[i].data);
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_latency_sweep();
      checks++;
      if ({s1_ready, s4_ready} !== 2'b11) begin
         failures++;
         $display("FAIL sweep_ready: got %b expected 11", {s1_ready, s4_ready});
      end
      for (int a = 0; a < 16; a++) issue_s(1'b1, a, 8'($urandom));
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         issue_s(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom));
      end
      repeat (6) @(negedge clk);
      checks++;
      if (obs1_q.size() != exp1_q.size() || obs4_q.size() != exp4_q.size()) begin
         failures++;
         $display("FAIL sweep count: got %0d/%0d expected %0d/%0d",
                  obs1_q.size(), obs4_q.size(), exp1_q.size(), exp4_q.size());
      end
      for (int i = 0; i < exp1_q.size() && i < obs1_q.size(); i++) begin
         checks++;
         if (obs1_q[i] !== exp1_q[i]) begin
            failures++;
            $display("FAIL lat1[%0d]: got cyc=%0d err=%0b data=%h expected cyc=%0d err=%0b data=%h",
                     i, obs1_q[i].stamp, obs1_q[i].err, obs1_q[i].data, exp1_q[i].stamp, exp1_q[i].err, exp1_q[i].data);
         end
      end
      for (int i = 0; i < exp4_q.size() && i < obs4_q.size(); i++) begin
         checks++;
         if (obs4_q[i] !== exp4_q[i]) begin
            failures++;
            $display("FAIL lat4[%0d]: got cyc=%0d err=%0b data=%h expected cyc=%0d err=%0b data=%h",
                     i, obs4_q[i].stamp, obs4_q[i].err, obs4_q[i].data, exp4_q[i].stamp, exp4_q[i].err, exp4_q[i].data);
         end
      end
      obs1_q.delete(); exp1_q.delete(); obs4_q.delete(); exp4_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; rv = 1'b0; rop = 1'b0; raddr = '0; rwd = '0;
      sv = 1'b0; sop = 1'b0; saddr = '0; swd = '0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_back_to_back();
      test_random();
      test_out_of_range();
      test_reset_midstream();
      test_latency_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_hs.md
# ram_hs

Parametrised single-port synchronous RAM with a valid/ready request handshake and a configurable read-latency pipeline. After reset, a built-in clear sequencer zeroes every word. Out-of-range accesses are flagged rather than silently aliased. It replaces the select-edge-triggered memory in the LR3 datapath and serves as the storage element for later labs that need back-to-back accesses at one per clock.

## Interface
- WORD_SIZE, 20, data width in bits (exact width, no +1)
- WORD_AMOUNT, 30, number of words; valid addresses 0..WORD_AMOUNT-1
- READ_LATENCY, 2, cycles from request acceptance to response; legal 1..4
- ADDR_W, max(1, $clog2(WORD_AMOUNT)), derived, not overridden
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  1  0 = READ, 1 = WRITE
- req_addr  in  ADDR_W  word address
- req_wdata  in  WORD_SIZE  write data
- resp_valid  out  1  response strobe, one cycle per accepted request
- resp_rdata  out  WORD_SIZE  read data; 0 for writes and errors
- resp_err  out  1  address was >= WORD_AMOUNT

## Operation
- Accept = req_valid & req_ready at a rising edge. No response backpressure: the consumer must take every response.
- FSM states: CLEAR, RUN.
  - rst=1 forces CLEAR, clear counter = 0, all pipeline valid bits = 0.
  - In CLEAR, each cycle with rst=0 writes 0 to memory[counter] and increments the counter.
  - After writing word WORD_AMOUNT-1, the FSM moves to RUN.
  - req_ready = (state == RUN); it is registered.
- WRITE accepted, address in range: memory[addr] <= wdata at the accept edge.
- READ accepted, address in range: samples memory[addr] at the accept edge. The value is the post-write content for any write accepted in an earlier cycle.
- Out-of-range address, either op: memory is unchanged, resp_err=1, resp_rdata=0.
- Every accepted request, read or write, produces exactly one response. Responses come out in acceptance order.
- Pipeline: READ_LATENCY-deep shift of {valid, err, data}. The data path carries 0 for writes.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Clear duration: with rst deasserted before edge E0, words are cleared at edges E0..E0+WORD_AMOUNT-1. req_ready is 1 from the cycle after edge E0+WORD_AMOUNT-1.
  - Default parameters: 30 clear cycles.
- Request accepted at edge N: resp_valid=1 during the cycle after edge N+READ_LATENCY-1, for exactly one cycle.
  - READ_LATENCY=1: response visible the cycle right after acceptance.
- Throughput: one request per cycle sustained. Consecutive write then read to the same address returns the new data.
- rst asserted mid-operation:
  - In-flight responses are discarded; resp_valid stays 0.
  - The clear sequence restarts from address 0.
  - Memory is zeroed again.
- rst asserted during CLEAR: the counter restarts at 0.
- req_valid while req_ready=0: ignored, no state change. Requester must hold the request.
- Addresses WORD_AMOUNT..2^ADDR_W-1 are the only out-of-range cases. When WORD_AMOUNT is a power of two, resp_err is never set.

## Test plan
- Reset then idle (defaults): req_ready=0 for 30 cycles after rst falls, then 1. A READ of every address 0..29 returns rdata=0, err=0.
- Write 0xABCDE to addr 5, read addr 5 on the next cycle, READ_LATENCY=2: write response then read response on consecutive cycles, 2 cycles after each accept. Read response has rdata=0xABCDE.
- Back-to-back: write addr i with i*3 for i=0..29 every cycle, then read all 30 every cycle: 30 contiguous resp_valid pulses in order with rdata=i*3.
- Out-of-range: READ and WRITE at addr 31 with data 0xFFFFF: both responses have err=1, rdata=0. A later read of addr 0..29 shows no corruption.
- Reset mid-stream: issue 4 reads, assert rst for 1 cycle before any response: no resp_valid appears. req_ready is low for 30 cycles, and the previously written addr 5 reads back 0.
- Latency sweep: READ_LATENCY=1 and 4, WORD_AMOUNT=16, WORD_SIZE=8: response exactly 1 or 4 cycles after accept. resp_err is never set for any 4-bit address.
